output_argmax: RTL
==================

// Module: output_argmax
// PURPOSE
//  Classification stage directly downstream of the network top. Captures the output-layer vector
//  (one signed fixed-point value per output node) on a valid pulse and scans it serially, one
//  element per cycle. Returns the winning class index and its value on a valid/ready output handshake.
// PARAMETERS
//  NUM_CLASSES  `NUM_OL_NODES            number of output-layer values scanned (>=1)
//  WORD_WIDTH   `FIXED_POINT_WORD_WIDTH  signed fixed-point word width
//  IDX_WIDTH    ARGMAX_IDX_W(NUM_CLASSES) class index width = max(1,$clog2(NUM_CLASSES))
// PORTS
//  CLK             in   1                       single clock, rising edge
//  RSTN            in   1                       asynchronous, active-low reset
//  VALUES_IN       in   WORD_WIDTH x NUM_CLASSES signed output-layer vector (unpacked array)
//  VALID_IN        in   1                       1-cycle pulse; VALUES_IN valid this cycle
//  CLASS_OUT       out  IDX_WIDTH               index of the maximum element
//  MAX_VALUE_OUT   out  WORD_WIDTH              signed value of the maximum element
//  CONFIDENCE_OUT  out  WORD_WIDTH              max minus runner-up, unsigned saturated (ARGMAX_CONFIDENCE_EN only)
//  VALID_OUT       out  1                       result valid; held until accepted
//  READY_IN        in   1                       consumer accepts when VALID_OUT & READY_IN
//  BUSY_OUT        out  1                       high in SCAN or HOLD
//  DROP_OUT        out  1                       1-cycle pulse: VALID_IN arrived while BUSY_OUT, vector discarded
// BEHAVIOUR
//  - Reset (RSTN low, async): state=IDLE; all outputs and internal registers 0.
//  - FSM: IDLE -(VALID_IN)-> SCAN -(idx==NUM_CLASSES-1)-> HOLD -(READY_IN)-> IDLE.
//  - IDLE + VALID_IN:
//    - latch the full vector into a capture buffer
//    - max=v[0], idx=0, runner-up=most-negative word
//    - scan pointer=1
//    - if NUM_CLASSES==1, go straight to HOLD.
//  - SCAN: one compare per cycle on element v[p]; p increments each cycle.
//    - Strict signed greater-than: ties keep the lower index.
//    - New max: runner-up <= old max.
//    - Else, if v[p] > runner-up: runner-up <= v[p].
//  - Latency: VALID_IN in cycle 0 -> VALID_OUT high in cycle NUM_CLASSES (N=1: cycle 1).
//  - HOLD: VALID_OUT=1; CLASS_OUT/MAX_VALUE_OUT/CONFIDENCE_OUT stable until handshake.
//    - Handshake cycle: state returns to IDLE; VALID_OUT drops next cycle.
//    - Results are registered and keep their last values after VALID_OUT drops.
//  - VALID_IN while BUSY_OUT (SCAN or HOLD, including the handshake cycle): vector ignored;
//    DROP_OUT pulses in the next cycle. No queuing.
//  - VALID_IN in IDLE is always accepted; BUSY_OUT rises the next cycle.
//  - Reset mid-scan or mid-hold: result abandoned, no VALID_OUT; returns to IDLE.
//  - Arithmetic: signed compares only; no rounding; the capture buffer is not modified.
// CONFIGURATION
//  ARGMAX_CONFIDENCE_EN defined:
//    - runner-up tracked as above
//    - CONFIDENCE_OUT = max - runner-up, computed in WORD_WIDTH+1 bits, saturated to 2^(WORD_WIDTH-1)-1
//    - N=1 gives the saturated value.
//  Undefined: CONFIDENCE_OUT port and runner-up register are absent; all other behaviour identical.
// STRUCTURE
//  Shared package network_pkg:
//    - argmax_state_t enum {IDLE,SCAN,HOLD}
//    - ARGMAX_IDX_W() function
//    - WORD_MIN/WORD_MAX constants derived from `FIXED_POINT_WORD_WIDTH.
//  Sub-module argmax_cmp: combinational signed compare/update of (max,idx,runner-up) against one
//  candidate; instantiated once, driven by the scan pointer.
// TESTING (WORD_WIDTH=16, NUM_CLASSES=4, ARGMAX_CONFIDENCE_EN on unless noted)
//  1. VALUES_IN={10,-5,300,299}, READY_IN=1
//     -> VALID_OUT at cycle 4; CLASS_OUT=2; MAX_VALUE_OUT=300; CONFIDENCE_OUT=1.
//  2. Tie {7,7,-1,7} -> CLASS_OUT=0, MAX_VALUE_OUT=7, CONFIDENCE_OUT=0.
//  3. All-negative {-3,-2,-32768,-9} -> CLASS_OUT=1, MAX_VALUE_OUT=-2, CONFIDENCE_OUT=1.
//  4. Saturation {32767,-32768,-32768,-32768} -> CONFIDENCE_OUT=32767.
//  5. READY_IN low 5 cycles -> outputs stable; second VALID_IN in HOLD -> DROP_OUT 1 cycle;
//     result unchanged; accepted on READY_IN.
//  6. RSTN low at cycle 2 of scan -> outputs 0, no VALID_OUT.
//     Macro off -> test 1 gives CLASS_OUT=2, no CONFIDENCE_OUT port.

Source files
------------

// File: rtl/network_pkg.sv
// Shared network definitions: argmax FSM states, class-index width helper and word bounds.
// Falls back to 16-bit words / 4 output nodes when FIXED_POINT_WORD_WIDTH / NUM_OL_NODES are undefined.
`ifndef FIXED_POINT_WORD_WIDTH
`define FIXED_POINT_WORD_WIDTH 16
`endif
`ifndef NUM_OL_NODES
`define NUM_OL_NODES 4
`endif

package network_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } argmax_state_t;

  localparam int WORD_W = `FIXED_POINT_WORD_WIDTH;
  localparam logic signed [WORD_W-1:0] WORD_MIN = {1'b1, {(WORD_W-1){1'b0}}};
  localparam logic signed [WORD_W-1:0] WORD_MAX = {1'b0, {(WORD_W-1){1'b1}}};

  function automatic int ARGMAX_IDX_W(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational signed compare of one candidate against the running (max, index, runner-up).
// Runner-up ports exist only when ARGMAX_CONFIDENCE_EN is defined.
module argmax_cmp #(
  parameter int WORD_WIDTH = 16,
  parameter int IDX_WIDTH  = 2
) (
`ifdef ARGMAX_CONFIDENCE_EN
  input  logic signed [WORD_WIDTH-1:0] cur_ru,
  output logic signed [WORD_WIDTH-1:0] new_ru,
`endif
  input  logic signed [WORD_WIDTH-1:0] cur_max,
  input  logic        [IDX_WIDTH-1:0]  cur_idx,
  input  logic signed [WORD_WIDTH-1:0] cand,
  input  logic        [IDX_WIDTH-1:0]  cand_idx,
  output logic signed [WORD_WIDTH-1:0] new_max,
  output logic        [IDX_WIDTH-1:0]  new_idx
);

  // Strict greater-than so ties keep the earlier (lower) index.
  always_comb begin
    new_max = cur_max;
    new_idx = cur_idx;
`ifdef ARGMAX_CONFIDENCE_EN
    new_ru  = cur_ru;
`endif
    if (cand > cur_max) begin
      new_max = cand;
      new_idx = cand_idx;
`ifdef ARGMAX_CONFIDENCE_EN
      new_ru  = cur_max;
`endif
    end
`ifdef ARGMAX_CONFIDENCE_EN
    else if (cand > cur_ru) begin
      new_ru = cand;
    end else begin
      new_ru = cur_ru;
    end
`else
    else begin
      new_max = cur_max;
      new_idx = cur_idx;
    end
`endif
  end

endmodule

// File: rtl/output_argmax.sv
// Serial argmax over the captured output-layer vector with a valid/ready result handshake.
// Optional feature macro: ARGMAX_CONFIDENCE_EN (adds runner-up tracking and CONFIDENCE_OUT).
`ifndef FIXED_POINT_WORD_WIDTH
`define FIXED_POINT_WORD_WIDTH 16
`endif
`ifndef NUM_OL_NODES
`define NUM_OL_NODES 4
`endif

module output_argmax
  import network_pkg::*;
#(
  parameter int NUM_CLASSES = `NUM_OL_NODES,
  parameter int WORD_WIDTH  = `FIXED_POINT_WORD_WIDTH,
  parameter int IDX_WIDTH   = ARGMAX_IDX_W(NUM_CLASSES)
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic signed [WORD_WIDTH-1:0] VALUES_IN [NUM_CLASSES],
  input  logic                         VALID_IN,
  output logic        [IDX_WIDTH-1:0]  CLASS_OUT,
  output logic signed [WORD_WIDTH-1:0] MAX_VALUE_OUT,
`ifdef ARGMAX_CONFIDENCE_EN
  output logic        [WORD_WIDTH-1:0] CONFIDENCE_OUT,
`endif
  output logic                         VALID_OUT,
  input  logic                         READY_IN,
  output logic                         BUSY_OUT,
  output logic                         DROP_OUT
);

  argmax_state_t state, state_nxt;

  logic signed [WORD_WIDTH-1:0] vals [NUM_CLASSES];
  logic signed [WORD_WIDTH-1:0] max_r;
  logic        [IDX_WIDTH-1:0]  idx_r;
  logic        [IDX_WIDTH-1:0]  ptr;
  logic signed [WORD_WIDTH-1:0] new_max;
  logic        [IDX_WIDTH-1:0]  new_idx;
  logic                         last;

`ifdef ARGMAX_CONFIDENCE_EN
  localparam logic signed [WORD_WIDTH-1:0] W_MIN = {1'b1, {(WORD_WIDTH-1){1'b0}}};
  localparam logic        [WORD_WIDTH-1:0] W_MAX = {1'b0, {(WORD_WIDTH-1){1'b1}}};

  logic signed [WORD_WIDTH-1:0] ru_r;
  logic signed [WORD_WIDTH-1:0] new_ru;

  // max >= runner-up always holds, so only the upper bound normally saturates.
  function automatic logic [WORD_WIDTH-1:0] sat_diff(input logic signed [WORD_WIDTH-1:0] a,
                                                     input logic signed [WORD_WIDTH-1:0] b);
    logic signed [WORD_WIDTH:0] d;
    d = {a[WORD_WIDTH-1], a} - {b[WORD_WIDTH-1], b};
    if (d[WORD_WIDTH]) begin
      sat_diff = '0;
    end else if (d[WORD_WIDTH-1]) begin
      sat_diff = W_MAX;
    end else begin
      sat_diff = d[WORD_WIDTH-1:0];
    end
  endfunction
`endif

  assign last = (ptr == IDX_WIDTH'(NUM_CLASSES - 1));

  argmax_cmp #(.WORD_WIDTH(WORD_WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_cmp (
`ifdef ARGMAX_CONFIDENCE_EN
    .cur_ru   (ru_r),
    .new_ru   (new_ru),
`endif
    .cur_max  (max_r),
    .cur_idx  (idx_r),
    .cand     (vals[ptr]),
    .cand_idx (ptr),
    .new_max  (new_max),
    .new_idx  (new_idx)
  );

  // State register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (VALID_IN) begin
          state_nxt = (NUM_CLASSES == 1) ? HOLD : SCAN;
        end else begin
          state_nxt = IDLE;
        end
      end
      SCAN: begin
        if (last) begin
          state_nxt = HOLD;
        end else begin
          state_nxt = SCAN;
        end
      end
      HOLD: begin
        if (READY_IN) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = HOLD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture buffer and running scan registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < NUM_CLASSES; i++) vals[i] <= '0;
      max_r <= '0;
      idx_r <= '0;
      ptr   <= '0;
`ifdef ARGMAX_CONFIDENCE_EN
      ru_r  <= '0;
`endif
    end else if (state == IDLE && VALID_IN) begin
      vals  <= VALUES_IN;
      max_r <= VALUES_IN[0];
      idx_r <= '0;
      ptr   <= IDX_WIDTH'(1);
`ifdef ARGMAX_CONFIDENCE_EN
      ru_r  <= W_MIN;
`endif
    end else if (state == SCAN) begin
      max_r <= new_max;
      idx_r <= new_idx;
      ptr   <= ptr + IDX_WIDTH'(1);
`ifdef ARGMAX_CONFIDENCE_EN
      ru_r  <= new_ru;
`endif
    end
  end

  // Result, handshake and status outputs; results persist after the handshake.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      CLASS_OUT      <= '0;
      MAX_VALUE_OUT  <= '0;
`ifdef ARGMAX_CONFIDENCE_EN
      CONFIDENCE_OUT <= '0;
`endif
      VALID_OUT      <= 1'b0;
      BUSY_OUT       <= 1'b0;
      DROP_OUT       <= 1'b0;
    end else begin
      BUSY_OUT <= (state_nxt != IDLE);
      DROP_OUT <= VALID_IN && (state != IDLE);
      if (state == IDLE && VALID_IN && NUM_CLASSES == 1) begin
        CLASS_OUT      <= '0;
        MAX_VALUE_OUT  <= VALUES_IN[0];
`ifdef ARGMAX_CONFIDENCE_EN
        CONFIDENCE_OUT <= W_MAX;
`endif
        VALID_OUT      <= 1'b1;
      end else if (state == SCAN && last) begin
        CLASS_OUT      <= new_idx;
        MAX_VALUE_OUT  <= new_max;
`ifdef ARGMAX_CONFIDENCE_EN
        CONFIDENCE_OUT <= sat_diff(new_max, new_ru);
`endif
        VALID_OUT      <= 1'b1;
      end else if (state == HOLD && READY_IN) begin
        VALID_OUT <= 1'b0;
      end
    end
  end

endmodule
